// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit count and
// active-low glyphs in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

    localparam logic [SEG_W-1:0]      SEG_OFF = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph_c
);

    always_comb begin
        glyph_c = SEG_OFF;
        case (nibble)
            4'h0: glyph_c = SEG_0;
            4'h1: glyph_c = SEG_1;
            4'h2: glyph_c = SEG_2;
            4'h3: glyph_c = SEG_3;
            4'h4: glyph_c = SEG_4;
            4'h5: glyph_c = SEG_5;
            4'h6: glyph_c = SEG_6;
            4'h7: glyph_c = SEG_7;
            4'h8: glyph_c = SEG_8;
            4'h9: glyph_c = SEG_9;
            4'hA: glyph_c = SEG_A;
            4'hB: glyph_c = SEG_B;
            4'hC: glyph_c = SEG_C;
            4'hD: glyph_c = SEG_D;
            4'hE: glyph_c = SEG_E;
            4'hF: glyph_c = SEG_F;
            default: glyph_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode display scanner, stepped by rising edges of the
// divider's scan_clk after synchronizing it into the clk_in domain.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   scan_prev_q;
    logic                   tick;
    logic                   drive_pend;
    logic [IDX_W-1:0]       idx;

    logic [VALUE_W-1:0]     sh_value;
    logic [NUM_DIGITS-1:0]  sh_dp;
    logic                   sh_blank_lz;

    logic [NIB_W-1:0]       nib_c;
    logic [SEG_W-1:0]       glyph_c;
    logic                   lead_zero_c;
    logic [NUM_DIGITS-1:0]  an_drive_c;
    logic [SEG_W-1:0]       seg_drive_c;
    logic                   dp_drive_c;

    // Synchronizer plus one extra flop for rising-edge detection.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            scan_prev_q <= 1'b0;
            tick        <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], scan_clk};
            scan_prev_q <= sync_q[SYNC_STAGES-1];
            tick        <= sync_q[SYNC_STAGES-1] & ~scan_prev_q;
        end
    end

    // Digit index and per-scan snapshot; the snapshot is taken on the wrap to digit 0.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            idx         <= 2'd3;
            drive_pend  <= 1'b0;
            sh_value    <= '0;
            sh_dp       <= '0;
            sh_blank_lz <= 1'b0;
        end else begin
            drive_pend <= tick;
            if (tick) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    sh_value    <= value;
                    sh_dp       <= dp_in;
                    sh_blank_lz <= blank_lz;
                end
            end
        end
    end

    always_comb begin
        nib_c       = sh_value[3:0];
        lead_zero_c = 1'b0;
        case (idx)
            2'd0: begin
                nib_c       = sh_value[3:0];
                lead_zero_c = 1'b0;
            end
            2'd1: begin
                nib_c       = sh_value[7:4];
                lead_zero_c = (sh_value[15:4] == 12'h000);
            end
            2'd2: begin
                nib_c       = sh_value[11:8];
                lead_zero_c = (sh_value[15:8] == 8'h00);
            end
            default: begin
                nib_c       = sh_value[15:12];
                lead_zero_c = (sh_value[15:12] == 4'h0);
            end
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble  (nib_c),
        .glyph_c (glyph_c)
    );

    // Blanked leading zeros keep the anode active so the decimal point can still show.
    always_comb begin
        an_drive_c  = ~(4'b0001 << idx);
        seg_drive_c = (sh_blank_lz && lead_zero_c) ? SEG_OFF : glyph_c;
        dp_drive_c  = ~sh_dp[idx];
    end

    // Disable wins; a tick opens a one-cycle dark gap before the new digit loads.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (!enable) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (tick) begin
            an  <= AN_OFF;
        end else if (drive_pend) begin
            an  <= an_drive_c;
            seg <= seg_drive_c;
            dp  <= dp_drive_c;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It consumes `divided_clk` from the clock divider as a slow scan reference, synchronizes it into the `clk_in` domain and edge-detects it. On each scan tick it advances to the next digit, decodes that digit's hex nibble and drives active-low anodes, segments and decimal point. All logic runs on `clk_in`; `scan_clk` is never used as a clock.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — flip-flops in the `scan_clk` synchronizer, minimum 2.

Ports:
- `clk_in`  input  1  — system clock.
- `rst`  input  1  — reset, asynchronous, active-high.
- `scan_clk`  input  1  — slow square wave from the clock divider, asynchronous to `clk_in`.
- `enable`  input  1  — 1 = display on, 0 = all digits dark.
- `value`  input  16  — four hex nibbles. Digit 0 = `value[3:0]` (rightmost), digit 3 = `value[15:12]`.
- `dp_in`  input  4  — per-digit decimal point, 1 = lit.
- `blank_lz`  input  1  — 1 = blank leading zero digits.
- `an`  output  4  — anodes, active-low, one-hot-low when driving.
- `seg`  output  7  — segments, active-low, `{g,f,e,d,c,b,a}`.
- `dp`  output  1  — decimal point, active-low.

## Operation
- Synchronizer: `scan_clk` passes through `SYNC_STAGES` flip-flops, then one extra flip-flop for edge detection. A registered `tick` pulses for 1 cycle on each rising edge of `scan_clk`. Falling edges are ignored.
- Digit index `idx` (2 bits) resets to 3, so the first tick wraps to 0.
- Per tick, two phases:
  - Blank cycle: `an`=4'b1111 for exactly 1 cycle (anti-ghosting). `idx` increments mod 4.
  - Drive: the next cycle loads `an`, `seg` and `dp` for the new `idx`. They hold until the next tick's blank cycle.
- Shadow register: when `idx` wraps to 0, `value`, `dp_in` and `blank_lz` are latched into a shadow copy. All four digits of a scan come from the same snapshot, so there is no tearing.
- Decode uses standard hex glyphs:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - A → 7'b0001000
  - F → 7'b0001110
- Leading-zero blanking: with `blank_lz`=1, digit k (k=3..1) is blanked if its nibble and all higher nibbles are 0. Digit 0 is never blanked. A blanked digit drives `seg`=7'b1111111, but `an` stays active and `dp` still follows `dp_in`.
- Disable: with `enable`=0, `an`=4'b1111, `seg`=7'b1111111 and `dp`=1 from the next cycle. Ticks keep advancing `idx` and the shadow register, so re-enabling resumes at the next tick's digit.

## Timing
- Reset values: `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `idx`=3, synchronizer flops 0, `tick`=0, shadow=0.
- Latency with `SYNC_STAGES`=2: `scan_clk` is first sampled high at edge E1. `tick` is high after E3, blank occurs after E4, and the new digit drives after E5.
- Scan rate: with the divider toggling every 40001 cycles, there is one tick per 80002 `clk_in` cycles, i.e. about 4 ms per full scan.
- `scan_clk` high or low for fewer than `SYNC_STAGES`+1 cycles may be missed. That is permitted; a pulse never produces more than one tick.
- Asserting `rst` mid-scan forces all reset values immediately (asynchronous). After release, the first rising edge of `scan_clk` drives digit 0.
- `value` changes mid-scan take effect at the next wrap to digit 0.
- If a tick coincides with an `enable` 0→1 transition, the normal blank→drive sequence applies.

## Structure
- Package `seg7_pkg`:
  - `NUM_DIGITS`=4.
  - Glyph constants `SEG_0`…`SEG_F`.
  - `SEG_OFF`=7'b1111111.
  - `AN_OFF`=4'b1111.
- Sub-module `hex_to_seg7`: combinational nibble → active-low 7-bit glyph, built from the package constants.
- Top level contains the synchronizer, edge detector, `idx` counter, shadow register, blanking logic and output registers.

## Test plan
- Reset, then `enable`=1, `value`=16'h1234, `scan_clk` toggling every 20 cycles → `an` sequence 1110, 1101, 1011, 0111 with `seg` = glyphs 4, 3, 2, 1. Each step is preceded by one `an`=1111 cycle, and each new digit appears exactly 5 cycles after the sampled rising edge.
- `value`=16'h00A0, `blank_lz`=1, `dp_in`=4'b1000 → digit 3: `seg`=1111111 with `dp`=0. Digit 2: `seg`=1111111. Digit 1: `seg`=0001000. Digit 0: `seg`=1000000.
- `value` changed from 16'h1111 to 16'h8888 while digit 1 is driving → digits 2 and 3 still show 1 (`seg`=1111001). Digit 0 of the next scan shows 0000000.
- `enable` dropped mid-digit → all outputs off the next cycle while `idx` keeps advancing. On re-enable, the next tick's digit is shown.
- `rst` asserted with digit 2 driving → outputs at reset values in the same cycle, asynchronously. After release, the first tick drives digit 0 with `an`=1110.
- 1-cycle high glitch on `scan_clk` → at most one tick, and never two consecutive advances.
